// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Command-side front end for a 32-bit combinational ALU. Commands {op, a, b} are
// accepted through a valid/ready handshake into a small FIFO. They are driven one
// at a time onto registered ALU inputs. The ALU result is captured one cycle later
// and returned through a valid/ready response port with an 8-bit sequence tag.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_op/cmd_a/cmd_b are the payload
//   alu_a/alu_b/alu_op   registered operands and opcode to the ALU
//   alu_c                combinational ALU result
//   rsp_valid/rsp_ready  response handshake; rsp_data is the result, rsp_tag its
//                        sequence number
//   count                FIFO occupancy (0..DEPTH)
//   err                  sticky self-check mismatch flag
//
// Optional feature: define ALU_SEQ_CHECK_EN to build an internal reference ALU.
// The model compares its result against alu_c at each capture and sets err on a
// mismatch. Without the macro, err is tied low.

module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [31:0]              cmd_a,
    input  logic [31:0]              cmd_b,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [2:0]               alu_op,
    input  logic [31:0]              alu_c,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic [7:0]               rsp_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of two
    logic [2:0]      mem_op_q [DEPTH];
    logic [2:0]      mem_op_d [DEPTH];
    logic [31:0]     mem_a_q  [DEPTH];
    logic [31:0]     mem_a_d  [DEPTH];
    logic [31:0]     mem_b_q  [DEPTH];
    logic [31:0]     mem_b_d  [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0]     alu_a_q, alu_a_d;
    logic [31:0]     alu_b_q, alu_b_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [7:0]      rsp_tag_q, rsp_tag_d;

    logic            push;
    logic            load_alu;
    logic            capture;
    logic            rsp_done;
    logic            not_empty;

    // Ready looks only at the registered count: a same-cycle pop never frees a slot
    assign cmd_ready = !reset && (count_q < CntW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign not_empty = (count_q != '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (not_empty) state_d = StWait;
            StWait: state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = not_empty ? StWait : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: control outputs ----------------
    always_comb begin
        load_alu = 1'b0;
        capture  = 1'b0;
        rsp_done = 1'b0;
        unique case (state_q)
            StIdle: load_alu = not_empty;
            // The head entry stays in the FIFO while the ALU settles; it is popped here
            StWait: capture = 1'b1;
            StResp: begin
                rsp_done = rsp_ready;
                load_alu = rsp_ready && not_empty;
            end
            default: ;
        endcase
    end

    // ---------------- FIFO next state ----------------
    always_comb begin
        mem_op_d = mem_op_q;
        mem_a_d  = mem_a_q;
        mem_b_d  = mem_b_q;
        tail_d   = tail_q;
        head_d   = head_q;
        if (push) begin
            mem_op_d[tail_q] = cmd_op;
            mem_a_d[tail_q]  = cmd_a;
            mem_b_d[tail_q]  = cmd_b;
            tail_d           = tail_q + PtrW'(1);
        end
        if (capture) begin
            head_d = head_q + PtrW'(1);
        end
        unique case ({push, capture})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        if (load_alu) begin
            alu_a_d  = mem_a_q[head_q];
            alu_b_d  = mem_b_q[head_q];
            alu_op_d = mem_op_q[head_q];
        end
        if (capture) begin
            rsp_data_d  = alu_c;
            rsp_valid_d = 1'b1;
        end
        if (rsp_done) begin
            rsp_valid_d = 1'b0;
            rsp_tag_d   = rsp_tag_q + 8'd1;
        end
    end

    // Storage array carries no reset: stale entries are never read once pointers clear
    always_ff @(posedge clk) begin
        mem_op_q <= mem_op_d;
        mem_a_q  <= mem_a_d;
        mem_b_q  <= mem_b_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    // Reference ALU evaluated on the registered operands the real ALU is seeing
    logic [31:0] exp_c;
    logic        err_q, err_d;

    always_comb begin
        exp_c = '0;
        unique case (alu_op_q)
            3'b000:  exp_c = alu_a_q + alu_b_q;
            3'b001:  exp_c = alu_a_q - alu_b_q;
            3'b010:  exp_c = alu_a_q & alu_b_q;
            3'b011:  exp_c = alu_a_q | alu_b_q;
            3'b100:  exp_c = (|alu_b_q[31:5]) ? 32'd0 : (alu_a_q >> alu_b_q[4:0]);
            default: exp_c = (|alu_b_q[31:5]) ? {32{alu_a_q[31]}}
                                             : 32'($signed(alu_a_q) >>> alu_b_q[4:0]);
        endcase
    end

    always_comb begin
        err_d = err_q | (capture && (exp_c != alu_c));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign count     = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: behavioural ALU attached to the alu_* port,
// scoreboard of expected results filled on command acceptance and drained on
// each response handshake. A command with A == MAGIC sees a corrupted ALU result.

module tb_alu_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_c;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic [2:0]  count;
    logic        err;

    int          n_vec = 0;
    int          n_err = 0;
    int          hs_cnt = 0;
    int          ready_mode = 0;  // 0: low, 1: high, 2: random
    logic [31:0] exp_q[$];

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return (b >= 32) ? 32'd0 : (a >> b[4:0]);
            default: return (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
        endcase
    endfunction

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        return ref_alu(op, a, b) ^ {31'd0, (a == MAGIC)};
    endfunction

    always_comb alu_c = alu_model(alu_op, alu_a, alu_b);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // rsp_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Response monitor: handshake known at negedge completes at the next posedge
    initial begin
        logic        hold;
        logic [31:0] hold_data;
        logic [7:0]  hold_tag;
        logic [31:0] e;
        hold = 1'b0;
        hold_data = '0;
        hold_tag = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                hs_cnt = 0;
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check_eq("rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
                    check_eq("rsp_data_stable", rsp_data, hold_data);
                    check_eq("rsp_tag_stable", {24'd0, rsp_tag}, {24'd0, hold_tag});
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("rsp_spurious", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("rsp_data", rsp_data, e);
                        check_eq("rsp_tag", {24'd0, rsp_tag}, 32'(hs_cnt & 255));
                    end
                    hs_cnt++;
                    hold = 1'b0;
                end else begin
                    hold = rsp_valid;
                    hold_data = rsp_data;
                    hold_tag = rsp_tag;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_cmd_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp);
        logic acc;
        acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (acc) exp_q.push_back(exp);
        else check_eq("push_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        push_cmd_exp(op, a, b, alu_model(op, a, b));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !rsp_valid) break;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_alu_a"}, alu_a, 32'd0);
        check_eq({tag, "_alu_b"}, alu_b, 32'd0);
        check_eq({tag, "_alu_op"}, {29'd0, alu_op}, 32'd0);
        check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({tag, "_rsp_data"}, rsp_data, 32'd0);
        check_eq({tag, "_rsp_tag"}, {24'd0, rsp_tag}, 32'd0);
        check_eq({tag, "_count"}, {29'd0, count}, 32'd0);
        check_eq({tag, "_err"}, {31'd0, err}, 32'd0);
        check_eq({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] op_exp [8];
        op_exp[0] = 32'h8000_0014;
        op_exp[1] = 32'h8000_000C;
        op_exp[2] = 32'h0000_0000;
        op_exp[3] = 32'h8000_0014;
        op_exp[4] = 32'h0800_0001;
        op_exp[5] = 32'hF800_0001;
        op_exp[6] = 32'hF800_0001;
        op_exp[7] = 32'hF800_0001;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
        ready_mode = 1;

        // Single command: operands one cycle after accept, result two cycles after
        push_cmd_exp(3'b000, 32'd7, 32'd5, 32'd12);
        check_eq("single_count", {29'd0, count}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("single_alu_a", alu_a, 32'd7);
        check_eq("single_alu_b", alu_b, 32'd5);
        check_eq("single_alu_op", {29'd0, alu_op}, 32'd0);
        check_eq("single_valid_early", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("single_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("single_data", rsp_data, 32'd12);
        check_eq("single_tag", {24'd0, rsp_tag}, 32'd0);
        check_eq("single_err", {31'd0, err}, 32'd0);
        wait_drain();

        // All opcodes in order
        for (int i = 0; i < 8; i++) begin
            push_cmd_exp(3'(i), 32'h8000_0010, 32'd4, op_exp[i]);
        end
        wait_drain();

        // Full FIFO under back-pressure
        ready_mode = 0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push_cmd(3'(i % 5), 32'h1000 + 32'(i), 32'(i + 1));
                end
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                check_eq("full_count", {29'd0, count}, 32'd4);
                check_eq("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
                check_eq("full_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                @(posedge clk);
                #1;
                ready_mode = 1;
            end
        join
        wait_drain();

        // Shift amount of 32
        push_cmd_exp(3'b100, 32'h8000_0000, 32'd32, 32'h0000_0000);
        push_cmd_exp(3'b101, 32'h8000_0000, 32'd32, 32'hFFFF_FFFF);
        wait_drain();

        // Random traffic with random back-pressure; long enough for the tag to wrap
        ready_mode = 2;
        for (int i = 0; i < 270; i++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom();
            push_cmd(3'($urandom_range(0, 7)), $urandom(), b);
        end
        wait_drain();

        // Corrupted ALU result on one command
        ready_mode = 1;
        check_eq("selfchk_err_before", {31'd0, err}, 32'd0);
        push_cmd(3'b000, 32'd100, 32'd1);
        push_cmd(3'b000, MAGIC, 32'd1);
        push_cmd(3'b011, 32'h00F0, 32'h000F);
        wait_drain();
`ifdef ALU_SEQ_CHECK_EN
        check_eq("selfchk_err_set", {31'd0, err}, 32'd1);
`else
        check_eq("selfchk_err_off", {31'd0, err}, 32'd0);
`endif
        push_cmd(3'b001, 32'd50, 32'd8);
        wait_drain();
`ifdef ALU_SEQ_CHECK_EN
        check_eq("selfchk_err_sticky", {31'd0, err}, 32'd1);
`else
        check_eq("selfchk_err_off2", {31'd0, err}, 32'd0);
`endif

        // Reset while the second queued command is in WAIT
        ready_mode = 0;
        push_cmd(3'b000, 32'd1, 32'd2);
        push_cmd(3'b001, 32'd3, 32'd4);
        push_cmd(3'b010, 32'd5, 32'd6);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(posedge clk);
                #1;
                seen = rsp_valid;
            end
            check_eq("midrst_first_valid", {31'd0, seen}, 32'd1);
            ready_mode = 1;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(posedge clk);
                #1;
                seen = !rsp_valid;
            end
            check_eq("midrst_handshake", {31'd0, seen}, 32'd1);
        end
        reset = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        check_reset_vals("midrst");
        reset = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_eq("midrst_no_valid", {31'd0, rsp_valid}, 32'd0);
            check_eq("midrst_count", {29'd0, count}, 32'd0);
        end
        push_cmd_exp(3'b001, 32'd9, 32'd4, 32'd5);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("after_rst_tag", {24'd0, rsp_tag}, 32'd0);
        check_eq("after_rst_data", rsp_data, 32'd5);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
